// File: rtl/strobe_serial_tx.sv
// strobe_serial_tx
//
// Parallel-to-serial transmitter with a qualifying strobe. A word is taken on
// a valid/ready handshake and shifted out MSB first on ser_data. Each bit is
// presented for HALF_PERIOD cycles with the strobe low (setup), then held for
// HALF_PERIOD cycles with the strobe high (hold). A downstream capture flop
// clocked by the strobe's rising edge therefore sees HALF_PERIOD cycles of
// setup and hold. ser_data only ever changes on the edge where the strobe
// falls, or is low already.
//
// Ports:
//   clk         single clock, all state updates on its rising edge
//   rst_n       asynchronous active-low reset
//   tx_data     word to send, sampled only when the handshake completes
//   tx_valid    upstream has a word
//   tx_ready    idle and able to accept a word (registered)
//   ser_data    serial data, MSB first, 0 when idle (registered)
//   ser_strobe  sampling strobe, rising edge marks valid ser_data (registered)
//   busy        frame in progress (registered)
//   done        one-cycle pulse on the edge a frame completes (registered)

module strobe_serial_tx #(
    parameter int WIDTH       = 8,
    parameter int HALF_PERIOD = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic             ser_data,
    output logic             ser_strobe,
    output logic             busy,
    output logic             done
);

    localparam int PHASE_W = $clog2(HALF_PERIOD + 1);
    localparam int BIT_W   = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(HALF_PERIOD - 1);
    localparam logic [PHASE_W-1:0] PHASE_ONE  = PHASE_W'(1);
    localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(WIDTH - 1);
    localparam logic [BIT_W-1:0]   BIT_ONE    = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        HOLD
    } state_t;

    state_t             state_q,    state_d;
    logic [PHASE_W-1:0] phase_q,    phase_d;
    logic [BIT_W-1:0]   bit_q,      bit_d;
    logic [WIDTH-1:0]   shift_q,    shift_d;
    logic               ser_data_q, ser_data_d;
    logic               strobe_q,   strobe_d;
    logic               busy_q,     busy_d;
    logic               ready_q,    ready_d;
    logic               done_q,     done_d;

    logic phase_end;

    // A phase (setup or hold) ends on the HALF_PERIOD-th edge after it began,
    // and the counter is reloaded to 0 whenever a new phase starts.
    assign phase_end = (phase_q == PHASE_LAST);

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        ser_data_d = ser_data_q;
        strobe_d   = strobe_q;
        busy_d     = busy_q;
        ready_d    = ready_q;
        done_d     = 1'b0;

        case (state_q)
            IDLE: begin
                // ready_q rather than a combinational ready keeps every
                // output a plain flop with no path back from tx_valid.
                if (tx_valid && ready_q) begin
                    state_d    = SETUP;
                    phase_d    = '0;
                    bit_d      = BIT_LAST;
                    shift_d    = tx_data;
                    ser_data_d = tx_data[WIDTH-1];
                    strobe_d   = 1'b0;
                    busy_d     = 1'b1;
                    ready_d    = 1'b0;
                end
            end

            SETUP: begin
                if (phase_end) begin
                    state_d  = HOLD;
                    phase_d  = '0;
                    strobe_d = 1'b1;
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            HOLD: begin
                if (phase_end) begin
                    phase_d  = '0;
                    strobe_d = 1'b0;
                    if (bit_q != '0) begin
                        // Next bit goes out on the same edge the strobe falls.
                        state_d    = SETUP;
                        bit_d      = bit_q - BIT_ONE;
                        shift_d    = shift_q << 1;
                        ser_data_d = shift_d[WIDTH-1];
                    end else begin
                        state_d    = IDLE;
                        shift_d    = '0;
                        ser_data_d = 1'b0;
                        busy_d     = 1'b0;
                        ready_d    = 1'b1;
                        done_d     = 1'b1;
                    end
                end else begin
                    phase_d = phase_q + PHASE_ONE;
                end
            end

            default: begin
                state_d    = IDLE;
                phase_d    = '0;
                bit_d      = '0;
                shift_d    = '0;
                ser_data_d = 1'b0;
                strobe_d   = 1'b0;
                busy_d     = 1'b0;
                ready_d    = 1'b1;
            end
        endcase
    end

    // Reset drops any partial frame; tx_ready comes out of reset high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            ser_data_q <= 1'b0;
            strobe_q   <= 1'b0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            ser_data_q <= ser_data_d;
            strobe_q   <= strobe_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            done_q     <= done_d;
        end
    end

    assign tx_ready   = ready_q;
    assign ser_data   = ser_data_q;
    assign ser_strobe = strobe_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_strobe_serial_tx.sv
// tb_strobe_serial_tx
//
// Bench for strobe_serial_tx. Three instances cover the configurations of
// interest: A (WIDTH=8, HALF_PERIOD=2), B (WIDTH=8, HALF_PERIOD=1) and
// C (WIDTH=1, HALF_PERIOD=3). Each instance has a strobe-clocked capture
// process acting as the downstream receiver; words pushed into an expected
// queue at stimulus time are popped and compared when a full word has been
// captured. Cycle-level timing is checked on the falling clock edge.

module tb_strobe_serial_tx;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    logic [7:0] tx_data_a;
    logic       tx_valid_a, tx_ready_a, ser_data_a, ser_strobe_a, busy_a, done_a;
    logic [7:0] tx_data_b;
    logic       tx_valid_b, tx_ready_b, ser_data_b, ser_strobe_b, busy_b, done_b;
    logic [0:0] tx_data_c;
    logic       tx_valid_c, tx_ready_c, ser_data_c, ser_strobe_c, busy_c, done_c;

    int checks = 0;
    int errors = 0;
    int rises_b = 0;

    logic [7:0] exp_q_a[$];
    logic [7:0] exp_q_b[$];
    logic       exp_q_c[$];

    strobe_serial_tx #(.WIDTH(8), .HALF_PERIOD(2)) u_a (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_a), .tx_valid(tx_valid_a),
        .tx_ready(tx_ready_a), .ser_data(ser_data_a), .ser_strobe(ser_strobe_a),
        .busy(busy_a), .done(done_a)
    );

    strobe_serial_tx #(.WIDTH(8), .HALF_PERIOD(1)) u_b (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_b), .tx_valid(tx_valid_b),
        .tx_ready(tx_ready_b), .ser_data(ser_data_b), .ser_strobe(ser_strobe_b),
        .busy(busy_b), .done(done_b)
    );

    strobe_serial_tx #(.WIDTH(1), .HALF_PERIOD(3)) u_c (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data_c), .tx_valid(tx_valid_c),
        .tx_ready(tx_ready_c), .ser_data(ser_data_c), .ser_strobe(ser_strobe_c),
        .busy(busy_c), .done(done_c)
    );

    // Receiver for A: shift in on each strobe rise, compare every 8 bits.
    initial begin : sb_a
        logic [7:0] cap;
        logic [7:0] exp;
        int n;
        cap = '0;
        n = 0;
        forever begin
            @(posedge ser_strobe_a or negedge rst_n);
            if (rst_n !== 1'b1) begin
                n = 0;
            end else begin
                cap = {cap[6:0], ser_data_a};
                n++;
                if (n == 8) begin
                    n = 0;
                    checks++;
                    if (exp_q_a.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_a_word: captured %h, expected no word", cap);
                    end else begin
                        exp = exp_q_a.pop_front();
                        if (cap !== exp) begin
                            errors++;
                            $display("[TB] FAIL sb_a_word: captured %h, expected %h", cap, exp);
                        end
                    end
                end
            end
        end
    end

    // Receiver for B; also counts strobe rises to catch extra pulses.
    initial begin : sb_b
        logic [7:0] cap;
        logic [7:0] exp;
        int n;
        cap = '0;
        n = 0;
        forever begin
            @(posedge ser_strobe_b or negedge rst_n);
            if (rst_n !== 1'b1) begin
                n = 0;
            end else begin
                rises_b++;
                cap = {cap[6:0], ser_data_b};
                n++;
                if (n == 8) begin
                    n = 0;
                    checks++;
                    if (exp_q_b.size() == 0) begin
                        errors++;
                        $display("[TB] FAIL sb_b_word: captured %h, expected no word", cap);
                    end else begin
                        exp = exp_q_b.pop_front();
                        if (cap !== exp) begin
                            errors++;
                            $display("[TB] FAIL sb_b_word: captured %h, expected %h", cap, exp);
                        end
                    end
                end
            end
        end
    end

    // Receiver for C: every strobe rise is a complete one-bit word.
    initial begin : sb_c
        logic exp;
        forever begin
            @(posedge ser_strobe_c);
            if (rst_n === 1'b1) begin
                checks++;
                if (exp_q_c.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL sb_c_word: captured %b, expected no word", ser_data_c);
                end else begin
                    exp = exp_q_c.pop_front();
                    if (ser_data_c !== exp) begin
                        errors++;
                        $display("[TB] FAIL sb_c_word: captured %b, expected %b", ser_data_c, exp);
                    end
                end
            end
        end
    end

    task automatic wait_ready_a();
        int n;
        n = 0;
        while (tx_ready_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("[TB] FAIL ready_a_timeout: tx_ready %b, expected 1", tx_ready_a);
        end
    endtask

    task automatic wait_done_a(input string name);
        int n;
        n = 0;
        while (done_a !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s_done_timeout: done %b, expected 1", name, done_a);
        end
    endtask

    // Send one word on A; with timing=1 check every output on cycles E0..E0+32.
    task automatic send_a(input logic [7:0] w, input bit timing);
        logic exp_strobe, exp_data;
        wait_ready_a();
        tx_valid_a = 1'b1;
        tx_data_a  = w;
        exp_q_a.push_back(w);
        @(negedge clk);
        tx_valid_a = 1'b0;
        if (timing) begin
            for (int c = 0; c <= 32; c++) begin
                exp_strobe = (c < 32) && (((c / 2) % 2) == 1);
                exp_data   = (c < 32) ? w[7 - (c / 4)] : 1'b0;
                checks += 4;
                if (ser_strobe_a !== exp_strobe) begin
                    errors++;
                    $display("[TB] FAIL timing_strobe c=%0d: got %b, expected %b", c, ser_strobe_a, exp_strobe);
                end
                if (ser_data_a !== exp_data) begin
                    errors++;
                    $display("[TB] FAIL timing_data c=%0d: got %b, expected %b", c, ser_data_a, exp_data);
                end
                if (done_a !== (c == 32)) begin
                    errors++;
                    $display("[TB] FAIL timing_done c=%0d: got %b, expected %b", c, done_a, (c == 32));
                end
                if (busy_a !== (c < 32) || tx_ready_a !== (c == 32)) begin
                    errors++;
                    $display("[TB] FAIL timing_busy_ready c=%0d: got busy %b ready %b, expected busy %b ready %b",
                             c, busy_a, tx_ready_a, (c < 32), (c == 32));
                end
                if (c < 32) @(negedge clk);
            end
        end else begin
            wait_done_a("send_a");
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks += 5;
        if (tx_ready_a !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, expected 1", tx_ready_a); end
        if (ser_data_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_data: got %b, expected 0", ser_data_a); end
        if (ser_strobe_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobe: got %b, expected 0", ser_strobe_a); end
        if (busy_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, expected 0", busy_a); end
        if (done_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, expected 0", done_a); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (tx_ready_a !== 1'b1 || busy_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle: got ready %b busy %b, expected ready 1 busy 0", tx_ready_a, busy_a);
        end
    endtask

    task automatic test_basic();
        send_a(8'hA5, 1'b1);
        @(negedge clk);
    endtask

    task automatic test_data_change();
        wait_ready_a();
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h0F;
        exp_q_a.push_back(8'h0F);
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (2) @(negedge clk);
        tx_data_a = 8'hF0;
        wait_done_a("data_change");
        @(negedge clk);
    endtask

    task automatic test_holdoff();
        wait_ready_a();
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h3C;
        exp_q_a.push_back(8'h3C);
        @(negedge clk);
        tx_data_a = 8'hFF;
        exp_q_a.push_back(8'hFF);
        for (int c = 0; c < 32; c++) begin
            checks++;
            if (tx_ready_a !== 1'b0) begin
                errors++;
                $display("[TB] FAIL holdoff_ready c=%0d: got %b, expected 0", c, tx_ready_a);
            end
            @(negedge clk);
        end
        checks++;
        if (tx_ready_a !== 1'b1 || done_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL holdoff_end: got ready %b done %b, expected ready 1 done 1", tx_ready_a, done_a);
        end
        @(negedge clk);
        tx_valid_a = 1'b0;
        checks++;
        if (busy_a !== 1'b1 || ser_data_a !== 1'b1 || tx_ready_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL holdoff_accept: got busy %b data %b ready %b, expected 1 1 0",
                     busy_a, ser_data_a, tx_ready_a);
        end
        wait_done_a("holdoff");
        @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        int seen_done;
        wait_ready_a();
        tx_valid_a = 1'b1;
        tx_data_a  = 8'h5A;
        @(negedge clk);
        tx_valid_a = 1'b0;
        repeat (9) @(negedge clk);
        checks++;
        if (busy_a !== 1'b1) begin
            errors++;
            $display("[TB] FAIL mid_busy: got %b, expected 1", busy_a);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (ser_strobe_a !== 1'b0 || ser_data_a !== 1'b0 || busy_a !== 1'b0 ||
            tx_ready_a !== 1'b1 || done_a !== 1'b0) begin
            errors++;
            $display("[TB] FAIL async_reset: got strobe %b data %b busy %b ready %b done %b, expected 0 0 0 1 0",
                     ser_strobe_a, ser_data_a, busy_a, tx_ready_a, done_a);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen_done = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done_a === 1'b1 || busy_a === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            errors++;
            $display("[TB] FAIL no_done_after_abort: got %0d active cycles, expected 0", seen_done);
        end
        send_a(8'hC3, 1'b0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int n;
        logic exp_strobe;
        n = 0;
        while (tx_ready_b !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_valid_b = 1'b1;
        tx_data_b  = 8'h01;
        exp_q_b.push_back(8'h01);
        @(negedge clk);
        tx_data_b = 8'h80;
        exp_q_b.push_back(8'h80);
        for (int c = 0; c <= 17; c++) begin
            exp_strobe = (c < 16) && ((c % 2) == 1);
            checks += 2;
            if (ser_strobe_b !== exp_strobe) begin
                errors++;
                $display("[TB] FAIL b2b_strobe c=%0d: got %b, expected %b", c, ser_strobe_b, exp_strobe);
            end
            if (tx_ready_b !== (c == 16)) begin
                errors++;
                $display("[TB] FAIL b2b_ready c=%0d: got %b, expected %b", c, tx_ready_b, (c == 16));
            end
            if (c < 17) @(negedge clk);
        end
        tx_valid_b = 1'b0;
        checks++;
        if (busy_b !== 1'b1 || ser_data_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_second_accept: got busy %b data %b, expected 1 1", busy_b, ser_data_b);
        end
        n = 0;
        while (done_b !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks += 2;
        if (done_b !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_done_timeout: done %b, expected 1", done_b);
        end
        if (rises_b != 16) begin
            errors++;
            $display("[TB] FAIL b2b_strobe_rises: got %0d, expected 16", rises_b);
        end
        @(negedge clk);
    endtask

    task automatic test_single_bit();
        int n;
        n = 0;
        while (tx_ready_c !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        tx_valid_c = 1'b1;
        tx_data_c  = 1'b1;
        exp_q_c.push_back(1'b1);
        @(negedge clk);
        tx_valid_c = 1'b0;
        for (int c = 0; c <= 6; c++) begin
            checks += 3;
            if (ser_data_c !== (c < 6)) begin
                errors++;
                $display("[TB] FAIL single_data c=%0d: got %b, expected %b", c, ser_data_c, (c < 6));
            end
            if (ser_strobe_c !== (c >= 3 && c < 6)) begin
                errors++;
                $display("[TB] FAIL single_strobe c=%0d: got %b, expected %b", c, ser_strobe_c, (c >= 3 && c < 6));
            end
            if (done_c !== (c == 6)) begin
                errors++;
                $display("[TB] FAIL single_done c=%0d: got %b, expected %b", c, done_c, (c == 6));
            end
            if (c < 6) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic test_queues_drained();
        checks++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0 || exp_q_c.size() != 0) begin
            errors++;
            $display("[TB] FAIL queues_drained: got %0d/%0d/%0d pending, expected 0/0/0",
                     exp_q_a.size(), exp_q_b.size(), exp_q_c.size());
        end
    endtask

    initial begin
        tx_valid_a = 1'b0; tx_data_a = '0;
        tx_valid_b = 1'b0; tx_data_b = '0;
        tx_valid_c = 1'b0; tx_data_c = '0;
        test_reset();
        test_basic();
        test_data_change();
        test_holdoff();
        test_reset_mid_frame();
        test_back_to_back();
        test_single_bit();
        test_queues_drained();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
